smart_bus_injector: RTL and testbench

- Edge-of-array transmitter that drives the vertical smart bus and the per-row select_top_in_smart strobes, so that a chosen row of smart MACs captures bypass words instead of its normal top_in.
- Accepts a command (target row, word count), pulls that many words from an upstream valid/ready stream, and presents each word on the bus with a one-cycle select strobe to the target row.
- Sits at the top of a systolic column, between the operand buffer and the column of smart MAC tiles.

---
 rtl/smart_bus_pkg.sv | 20 ++
 rtl/smart_bus_row_decoder.sv | 24 ++
 rtl/smart_bus_injector.sv | 122 ++++++++++++
 tb/tb_smart_bus_injector.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/smart_bus_pkg.sv
// Shared definitions for the smart-bus injector and the future receiver-side controller.
package smart_bus_pkg;

    // Controller state encoding
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SEND = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = S_IDLE,
        ST_SEND = S_SEND,
        ST_DONE = S_DONE
    } sb_state_t;

    // Row index width; a single-row column still needs a 1-bit index
    function automatic int row_w(input int rows);
        return (rows > 1) ? $clog2(rows) : 1;
    endfunction

endpackage

// File: rtl/smart_bus_row_decoder.sv
// Row index to one-hot select decoder with an out-of-range flag.
module smart_bus_row_decoder
    import smart_bus_pkg::*;
#(
    parameter int ROWS  = 4,
    parameter int ROW_W = row_w(ROWS)
) (
    input  logic [ROW_W-1:0] i_row,
    output logic [ROWS-1:0]  o_onehot,
    output logic             o_oor
);

    // An out-of-range index decodes to all zeros and raises o_oor
    always_comb begin
        o_onehot = '0;
        o_oor    = (32'(i_row) >= 32'(ROWS));
        for (int r = 0; r < ROWS; r++) begin
            if (i_row == ROW_W'(r)) begin
                o_onehot[r] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/smart_bus_injector.sv
// Drives the vertical smart bus and per-row select strobes from a command plus a word stream.
module smart_bus_injector
    import smart_bus_pkg::*;
#(
    parameter int WORD_SIZE = 16,
    parameter int ROWS      = 4,
    parameter int CNT_W     = 8,
    parameter int ROW_W     = row_w(ROWS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [ROW_W-1:0]     cmd_row,
    input  logic [CNT_W-1:0]     cmd_len,
    input  logic                 data_in_valid,
    output logic                 data_in_ready,
    input  logic [WORD_SIZE-1:0] data_in,
    output logic [WORD_SIZE-1:0] vertical_smart_bus_out,
    output logic [ROWS-1:0]      select_top_in_smart,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    sb_state_t            r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [ROW_W-1:0]     r_row;
    logic                 r_oor;
    logic [WORD_SIZE-1:0] r_bus;
    logic [ROWS-1:0]      r_sel;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_err;

    logic [ROW_W-1:0]     w_dec_row;
    logic [ROWS-1:0]      w_onehot;
    logic                 w_oor;
    logic                 w_word_hs;

    // In IDLE the decoder looks at the incoming command so its range flag can be
    // latched at accept time; afterwards it decodes the latched row.
    assign w_dec_row = (r_state == ST_IDLE) ? cmd_row : r_row;

    smart_bus_row_decoder #(
        .ROWS  (ROWS),
        .ROW_W (ROW_W)
    ) u_dec (
        .i_row    (w_dec_row),
        .o_onehot (w_onehot),
        .o_oor    (w_oor)
    );

    assign cmd_ready     = (r_state == ST_IDLE);
    assign data_in_ready = (r_state == ST_SEND);
    assign w_word_hs     = data_in_valid && data_in_ready;

    assign vertical_smart_bus_out = r_bus;
    assign select_top_in_smart    = r_sel;
    assign busy                   = r_busy;
    assign done                   = r_done;
    assign err                    = r_err;

    // Command FSM, remaining-word counter and registered bus/strobe outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_row   <= '0;
            r_oor   <= 1'b0;
            r_bus   <= '0;
            r_sel   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            // Strobe and completion flags are single-cycle pulses
            r_sel  <= '0;
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        r_row  <= cmd_row;
                        r_cnt  <= cmd_len;
                        r_oor  <= w_oor;
                        r_busy <= 1'b1;
                        if (cmd_len == '0) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                            r_err   <= w_oor;
                        end else begin
                            r_state <= ST_SEND;
                        end
                    end
                end
                ST_SEND: begin
                    if (w_word_hs) begin
                        // Out-of-range rows still drain words, just never strobe
                        r_bus <= data_in;
                        r_sel <= r_oor ? '0 : w_onehot;
                        r_cnt <= r_cnt - CNT_W'(1);
                        if (r_cnt == CNT_W'(1)) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                            r_err   <= r_oor;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_smart_bus_injector.sv
// Directed bench for the smart-bus injector with a word scoreboard and a small reference model.
`timescale 1ns/1ps
module tb_smart_bus_injector;

    typedef struct packed {
        logic [3:0]  sel;
        logic [15:0] data;
    } exp_t;

    logic        clk;
    logic        rst;

    // Main instance, four rows
    logic        cmd_valid, cmd_ready;
    logic [1:0]  cmd_row;
    logic [7:0]  cmd_len;
    logic        din_valid, din_ready;
    logic [15:0] din, bus;
    logic [3:0]  sel;
    logic        busy, done, err;

    // Second instance, three rows, for the out-of-range case
    logic        cmd_valid_b, cmd_ready_b;
    logic [1:0]  cmd_row_b;
    logic [7:0]  cmd_len_b;
    logic        din_valid_b, din_ready_b;
    logic [15:0] din_b, bus_b;
    logic [2:0]  sel_b;
    logic        busy_b, done_b, err_b;

    int checks;
    int failures;
    int cyc;

    // Reference model of the four-row instance
    int          m_state;  // 0 idle, 1 send, 2 done
    int          m_rem;
    logic [1:0]  m_row;
    logic        m_oor;
    logic [15:0] m_bus;
    exp_t        sbq[$];

    smart_bus_injector #(.WORD_SIZE(16), .ROWS(4), .CNT_W(8)) dut (
        .clk                    (clk),
        .rst                    (rst),
        .cmd_valid              (cmd_valid),
        .cmd_ready              (cmd_ready),
        .cmd_row                (cmd_row),
        .cmd_len                (cmd_len),
        .data_in_valid          (din_valid),
        .data_in_ready          (din_ready),
        .data_in                (din),
        .vertical_smart_bus_out (bus),
        .select_top_in_smart    (sel),
        .busy                   (busy),
        .done                   (done),
        .err                    (err)
    );

    smart_bus_injector #(.WORD_SIZE(16), .ROWS(3), .CNT_W(8)) dut_b (
        .clk                    (clk),
        .rst                    (rst),
        .cmd_valid              (cmd_valid_b),
        .cmd_ready              (cmd_ready_b),
        .cmd_row                (cmd_row_b),
        .cmd_len                (cmd_len_b),
        .data_in_valid          (din_valid_b),
        .data_in_ready          (din_ready_b),
        .data_in                (din_b),
        .vertical_smart_bus_out (bus_b),
        .select_top_in_smart    (sel_b),
        .busy                   (busy_b),
        .done                   (done_b),
        .err                    (err_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: push expected word on handshake, advance model, compare after the edge
    task automatic tick();
        bit   hs;
        exp_t e;
        hs = (!rst && m_state == 1 && din_valid);
        chk("din_ready", {31'd0, din_ready}, {31'd0, m_state == 1});
        if (hs) begin
            e.sel  = m_oor ? 4'b0000 : (4'b0001 << m_row);
            e.data = din;
            sbq.push_back(e);
        end
        @(posedge clk);
        #1;
        if (rst) begin
            m_state = 0; m_rem = 0; m_row = 2'd0; m_oor = 1'b0; m_bus = 16'h0;
        end else begin
            case (m_state)
                0: if (cmd_valid) begin
                    m_row   = cmd_row;
                    m_rem   = int'(cmd_len);
                    m_oor   = (cmd_row >= 2'd3) && 1'b0; // four rows: every 2-bit index is valid
                    m_state = (cmd_len == 8'd0) ? 2 : 1;
                end
                1: if (hs) begin
                    m_bus = din;
                    m_rem--;
                    if (m_rem == 0) m_state = 2;
                end
                default: m_state = 0;
            endcase
        end
        if (hs) begin
            e = sbq.pop_front();
            chk("sel_word", {28'd0, sel}, {28'd0, e.sel});
            chk("bus_word", {16'd0, bus}, {16'd0, e.data});
        end else begin
            chk("sel_idle", {28'd0, sel}, 32'd0);
            chk("bus_hold", {16'd0, bus}, {16'd0, m_bus});
        end
        chk("done", {31'd0, done}, {31'd0, m_state == 2});
        chk("err", {31'd0, err}, {31'd0, m_state == 2 && m_oor});
        chk("busy", {31'd0, busy}, {31'd0, m_state != 0});
        chk("cmd_ready", {31'd0, cmd_ready}, {31'd0, m_state == 0});
        chk("sel_b_zero", {29'd0, sel_b}, 32'd0);
        cyc++;
        if (cyc > 5000) begin
            $display("FAIL cycle_budget observed=%0d expected<=5000", cyc);
            $fatal(1, "cycle budget exceeded");
        end
    endtask

    initial begin
        checks = 0; failures = 0; cyc = 0;
        m_state = 0; m_rem = 0; m_row = 2'd0; m_oor = 1'b0; m_bus = 16'h0;
        rst = 1'b1;
        cmd_valid = 1'b0; cmd_row = 2'd0; cmd_len = 8'd0; din_valid = 1'b0; din = 16'h0;
        cmd_valid_b = 1'b0; cmd_row_b = 2'd0; cmd_len_b = 8'd0; din_valid_b = 1'b0; din_b = 16'h0;

        // Reset held three cycles, then idle
        repeat (3) tick();
        rst = 1'b0;
        repeat (2) tick();
        chk("idle_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("idle_bus", {16'd0, bus}, 32'd0);

        // Basic burst: row 2, three words
        cmd_valid = 1'b1; cmd_row = 2'd2; cmd_len = 8'd3;
        din_valid = 1'b1; din = 16'h1111;
        tick();
        cmd_valid = 1'b0;
        tick();
        din = 16'h2222;
        tick();
        din = 16'h3333;
        tick();
        chk("burst_last_sel", {28'd0, sel}, 32'h4);
        chk("burst_last_bus", {16'd0, bus}, 32'h3333);
        chk("burst_done", {31'd0, done}, 32'd1);
        din_valid = 1'b0;
        tick();
        chk("burst_ready_back", {31'd0, cmd_ready}, 32'd1);

        // Bubbles: row 0, two words with a gap
        cmd_valid = 1'b1; cmd_row = 2'd0; cmd_len = 8'd2;
        tick();
        cmd_valid = 1'b0;
        din_valid = 1'b1; din = 16'hAAAA;
        tick();
        din_valid = 1'b0; din = 16'h5555;
        tick();
        chk("bubble_hold", {16'd0, bus}, 32'hAAAA);
        din_valid = 1'b1; din = 16'hBBBB;
        tick();
        chk("bubble_second", {16'd0, bus}, 32'hBBBB);
        din_valid = 1'b0;
        tick();

        // Zero length: row 1, nothing consumed even with data offered
        cmd_valid = 1'b1; cmd_row = 2'd1; cmd_len = 8'd0;
        din_valid = 1'b1; din = 16'hCCCC;
        tick();
        chk("zero_done", {31'd0, done}, 32'd1);
        cmd_valid = 1'b0;
        tick();
        din_valid = 1'b0;
        tick();

        // Out of range on the three-row instance: row 3, two words drained
        cmd_valid_b = 1'b1; cmd_row_b = 2'd3; cmd_len_b = 8'd2;
        din_valid_b = 1'b1; din_b = 16'h5A5A;
        chk("oor_cmd_ready", {31'd0, cmd_ready_b}, 32'd1);
        tick();
        cmd_valid_b = 1'b0;
        chk("oor_ready1", {31'd0, din_ready_b}, 32'd1);
        tick();
        chk("oor_not_done", {31'd0, done_b}, 32'd0);
        chk("oor_ready2", {31'd0, din_ready_b}, 32'd1);
        din_b = 16'h6B6B;
        tick();
        chk("oor_done", {31'd0, done_b}, 32'd1);
        chk("oor_err", {31'd0, err_b}, 32'd1);
        chk("oor_busy", {31'd0, busy_b}, 32'd1);
        chk("oor_bus", {16'd0, bus_b}, 32'h6B6B);
        chk("oor_stop", {31'd0, din_ready_b}, 32'd0);
        din_valid_b = 1'b0;
        tick();
        chk("oor_idle", {31'd0, cmd_ready_b}, 32'd1);
        chk("oor_err_pulse", {31'd0, err_b}, 32'd0);

        // Reset mid-command: row 1, five words, reset after two
        cmd_valid = 1'b1; cmd_row = 2'd1; cmd_len = 8'd5;
        din_valid = 1'b1; din = 16'h0101;
        tick();
        cmd_valid = 1'b0;
        tick();
        din = 16'h0202;
        tick();
        rst = 1'b1; din = 16'h0303;
        tick();
        chk("rst_sel", {28'd0, sel}, 32'd0);
        chk("rst_bus", {16'd0, bus}, 32'd0);
        chk("rst_ready", {31'd0, cmd_ready}, 32'd1);
        rst = 1'b0; din_valid = 1'b0;
        tick();
        cmd_valid = 1'b1; cmd_row = 2'd3; cmd_len = 8'd1;
        din_valid = 1'b1; din = 16'hDDDD;
        tick();
        cmd_valid = 1'b0;
        tick();
        chk("fresh_sel", {28'd0, sel}, 32'h8);
        chk("fresh_done", {31'd0, done}, 32'd1);
        din_valid = 1'b0;
        tick();

        // Random valid pattern on a six-word burst
        cmd_valid = 1'b1; cmd_row = 2'($urandom_range(0, 3)); cmd_len = 8'd6;
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < 60 && m_state != 0; i++) begin
            din_valid = 1'($urandom_range(0, 1));
            din = 16'($urandom);
            tick();
        end
        din_valid = 1'b0;
        chk("rand_finished", m_state, 32'd0);
        tick();

        chk("scoreboard_empty", sbq.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
